lfsr_offset_finder: RTL and testbench

- Given a 17-bit LFSR feedback polynomial and a 17-bit received LFSR word, finds how many LFSR steps from a fixed seed produce that word.
- Used by the lighthouse pulse identifier, after the polynomial manager has supplied the polynomial and the first decoded data word.
- The resulting offset is the base iteration count from which per-sensor iteration values are derived.
- A result of 0 means "not found / invalid".

---
 rtl/lfsr_offset_finder_if.sv | 10 +
 rtl/lfsr_offset_finder.sv | 74 +++++++
 tb/tb_lfsr_offset_finder.sv | 112 +++++++++++
 3 files changed

// File: rtl/lfsr_offset_finder_if.sv
// lfsr_offset_finder_if: request/result bundle between a caller and lfsr_offset_finder.
interface lfsr_offset_finder_if;
  logic [16:0] polynomial;
  logic [16:0] data;
  logic        enable;
  logic [16:0] offset;
  logic        ready;
  modport master (output polynomial, data, enable, input offset, ready);
  modport slave (input polynomial, data, enable, output offset, ready);
endinterface

// File: rtl/lfsr_offset_finder.sv
// lfsr_offset_finder: counts LFSR steps from SEED to a received word; optional OFFSET_TIMEOUT_EN caps the search at MAX_ITER.
module lfsr_offset_finder #(
  parameter logic [16:0] SEED     = 17'h00001,
  parameter int          MAX_ITER = 131071
) (
  input  logic clk_72MHz,
  input  logic reset,
  lfsr_offset_finder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
`ifdef OFFSET_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif
  state_t state, state_n;
  logic [16:0] lfsr, lfsr_n, counter, counter_n, poly_q, poly_n, data_q, data_n, offset_n;
  logic en_q, stop;
  assign stop = counter == 17'h1FFFF || (TIMEOUT && counter == 17'(MAX_ITER));
  // Left unreset so enable already high at reset release is not seen as a rising edge.
  always_ff @(posedge clk_72MHz) en_q <= bus.enable;
  always_ff @(posedge clk_72MHz) begin
    if (reset) begin
      state      <= IDLE;
      lfsr       <= SEED;
      counter    <= '0;
      poly_q     <= '0;
      data_q     <= '0;
      bus.offset <= '0;
      bus.ready  <= 1'b0;
    end else begin
      state      <= state_n;
      lfsr       <= lfsr_n;
      counter    <= counter_n;
      poly_q     <= poly_n;
      data_q     <= data_n;
      bus.offset <= offset_n;
      bus.ready  <= state == DONE && bus.enable;
    end
  end
  always_comb begin
    state_n   = state;
    lfsr_n    = lfsr;
    counter_n = counter;
    poly_n    = poly_q;
    data_n    = data_q;
    offset_n  = bus.offset;
    case (state)
      IDLE: if (bus.enable && !en_q) begin
        poly_n    = bus.polynomial;
        data_n    = bus.data;
        lfsr_n    = SEED;
        counter_n = 17'd1;
        state_n   = bus.polynomial == '0 ? DONE : SEARCH;
        offset_n  = bus.polynomial == '0 ? '0 : bus.offset;
      end
      SEARCH: if (!bus.enable) begin
        state_n  = IDLE;
        offset_n = '0;
      end else if (lfsr == data_q) begin
        offset_n = counter;
        state_n  = DONE;
      end else if (stop) begin
        offset_n = '0;
        state_n  = DONE;
      end else begin
        lfsr_n    = {lfsr[15:0], ^(lfsr & poly_q)};
        counter_n = counter + 17'd1;
      end
      DONE: state_n = bus.enable ? DONE : IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_lfsr_offset_finder.sv
// tb_lfsr_offset_finder: directed and randomized searches against a step-counting reference model.
module tb_lfsr_offset_finder;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  lfsr_offset_finder_if bus ();
  lfsr_offset_finder dut (.clk_72MHz(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [16:0] step(input logic [16:0] s, input logic [16:0] p);
    return {s[15:0], ^(s & p)};
  endfunction

  // First step index (seed = 1) at which the sequence equals d; 0 if never within the period.
  function automatic int model_offset(input logic [16:0] p, input logic [16:0] d);
    logic [16:0] s = 17'h00001;
    if (p == '0) return 0;
    for (int n = 1; n <= 131071; n++) begin
      if (s == d) return n;
      s = step(s, p);
    end
    return 0;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input logic [16:0] p, input logic [16:0] d);
    int n = 0;
    int exp = model_offset(p, d);
    @(negedge clk);
    bus.polynomial = p;
    bus.data = d;
    bus.enable = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus.polynomial = 17'($urandom);
        bus.data = 17'($urandom);
      end
    end while (!bus.ready && n < 2000);
    check({tag, "_latency"}, n, p == '0 ? 2 : exp + 2);
    check({tag, "_offset"}, int'(bus.offset), exp);
    bus.enable = 1'b0;
    @(negedge clk);
    check({tag, "_ready_drop"}, int'(bus.ready), 0);
    check({tag, "_offset_kept"}, int'(bus.offset), exp);
  endtask

  initial begin
    logic [16:0] p, s;
    int k;
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.polynomial = 17'h12000;
    bus.data = 17'h00001;
    repeat (3) @(negedge clk);
    check("reset_ready", int'(bus.ready), 0);
    check("reset_offset", int'(bus.offset), 0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("held_enable_no_start", int'(bus.ready), 0);
    bus.enable = 1'b0;
    @(negedge clk);
    run("off1", 17'h12000, 17'h00001);
    run("off14", 17'h12000, 17'h02000);
    run("poly0", 17'h00000, 17'h0abcd);
    run("off3", 17'h12000, 17'h00004);
    @(negedge clk);
    bus.polynomial = 17'h12000;
    bus.data = 17'h02000;
    bus.enable = 1'b1;
    repeat (5) @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    check("abort_ready", int'(bus.ready), 0);
    check("abort_offset", int'(bus.offset), 0);
    repeat (20) @(negedge clk);
    check("abort_ready_later", int'(bus.ready), 0);
    run("pre_reset", 17'h12000, 17'h00004);
    @(negedge clk);
    bus.polynomial = 17'h12000;
    bus.data = 17'h02000;
    bus.enable = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_ready", int'(bus.ready), 0);
    check("midreset_offset", int'(bus.offset), 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("midreset_no_restart", int'(bus.ready), 0);
    bus.enable = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      p = 17'($urandom) | 17'h10000;
      k = $urandom_range(1, 400);
      s = 17'h00001;
      for (int j = 1; j < k; j++) s = step(s, p);
      run("random", p, s);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
